seg7_scan_decoder: RTL
======================

# seg7_scan_decoder

Receive-side counterpart of the team's multiplexed 7-segment display driver. It samples an active-low anode/segment bus scanned by an external driver, waits for each digit slot to settle, decodes the segment pattern back to a 4-bit value and holds one register per digit. It serves as an on-board display reader and as a reusable monitor in display-driver testbenches.

## Interface
- DIGITS, 4, number of anode lines / digit slots (1..8)
- STABLE_CYC, 16, i_clk cycles the synchronized anode+segment value must hold unchanged before capture (>=2)
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_an  in  DIGITS  anode select, active-low, bit n = digit n
- i_seg  in  7  segments, active-low, bit0=a … bit6=g
- o_digit  out  4*DIGITS  decoded value, digit n in [4n+3:4n]
- o_valid  out  DIGITS  digit n holds a decoded value (not blank, not error)
- o_err  out  DIGITS  last pattern seen on digit n was undecodable
- o_update  out  1  one-cycle pulse on every capture
- o_frame  out  1  one-cycle pulse when every digit has been captured since the last pulse

## Operation
- Two-flop synchronizer on i_an and i_seg; sync flops reset to all-ones (idle bus).
- Anode legal: exactly one bit of synced i_an low. All-high or multiple-low: illegal, never captured.
- Stability counter, width $clog2(STABLE_CYC): cleared whenever the synced {an,seg} differs from the previous cycle, otherwise increments; saturates.
- FSM states:
  - IDLE: anode illegal. Legal anode -> SETTLE, counter cleared.
  - SETTLE: any change -> SETTLE (counter cleared), or IDLE if anode became illegal. Counter == STABLE_CYC-1 with no change -> capture, -> HELD.
  - HELD: no further capture; any change -> SETTLE, or IDLE if anode illegal.
- Capture on digit n (the index of the low anode bit):
  - Pattern decodes (0–9; A–F per Configuration): o_digit[n] <= value, o_valid[n] <= 1, o_err[n] <= 0.
  - 7'b1111111 (blank): o_digit[n] unchanged, o_valid[n] <= 0, o_err[n] <= 0.
  - Any other pattern: o_digit[n] unchanged, o_valid[n] <= 0, o_err[n] <= 1.
  - All three cases pulse o_update and set seen[n].
- Frame mask seen[DIGITS-1:0]:
  - When the mask including the current capture is all-ones: o_frame pulses in the same cycle as o_update, and the mask clears.
  - A repeated capture of an already-seen digit does not pulse o_frame.
- Patterns 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000 (g..a).

## Timing
- Reset values: o_digit=0, o_valid=0, o_err=0, o_update=0, o_frame=0, state IDLE, counter 0, seen=0.
- Reset asserted mid-SETTLE or mid-HELD returns all of the above immediately. The first capture after release requires a full new settle.
- Latency: a bus change is sampled at edge k and is visible post-synchronizer at edge k+2. o_update/o_digit update at edge k+2+STABLE_CYC-1 and are registered, visible the following cycle.
- A bus change lasting fewer than STABLE_CYC synced cycles produces no capture.
- A value held indefinitely is captured exactly once.
- An anode change and a segment change in the same cycle count as one change.
- Outputs are all registered; no combinational path from the inputs.

## Configuration
- SEG7_HEX_EN defined: additionally decode A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 to 4'hA–4'hF.
- SEG7_HEX_EN undefined: those six patterns are errors (o_err set, o_valid cleared).

## Structure
- seg7_pkg contains:
  - FSM state localparams IDLE/SETTLE/HELD (one-hot, 3 bits).
  - SEG_BLANK constant.
  - Segment pattern constants SEG_0..SEG_F.
- Sub-module seg7_pattern_decode, combinational: 7-bit pattern in; 4-bit value, is_blank and is_err out; contains the SEG7_HEX_EN branch.
- Top contains the synchronizer, stability counter, FSM, per-digit registers and frame mask.

## Test plan
- Reset: after assert/release with an idle bus, all outputs are 0 and there is no o_update for 100 cycles.
- Settle: hold i_an=1110, i_seg=0100100 for 30 cycles (STABLE_CYC=16) -> one o_update, o_digit[3:0]=2, o_valid=0001. A second pulse must not occur.
- Glitch: from a held '2', drive i_seg=1111001 for 5 cycles, then back -> no o_update, digit stays 2.
- Full scan: digits 0..3 show 1,2,3,4 at 20 cycles each -> o_digit=16'h4321, o_valid=1111, exactly one o_frame coincident with the digit-3 capture.
- Hex and illegal bus:
  - i_an=1110, i_seg=0001000 -> with SEG7_HEX_EN, o_digit[3:0]=A and o_valid[0]=1. Without it, o_err[0]=1, o_valid[0]=0, digit unchanged.
  - i_an=1100 held -> no capture.
- Reset mid-operation: assert i_rst_n low 10 cycles into a settle -> outputs clear, and a capture occurs only after a full STABLE_CYC following release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: FSM state encodings and
// active-low segment patterns (bit6=g ... bit0=a).
package seg7_pkg;

  // One-hot FSM state encodings
  localparam logic [2:0] IDLE   = 3'b001;
  localparam logic [2:0] SETTLE = 3'b010;
  localparam logic [2:0] HELD   = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_SETTLE = SETTLE,
    ST_HELD   = HELD
  } state_t;

  // All segments off
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Decimal digits
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  // Hex letters A b C d E F
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low 7-segment pattern to a nibble.
// Optional feature macro: SEG7_HEX_EN (adds A..F; otherwise they are errors).
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_value,
  output logic       o_is_blank,
  output logic       o_is_err
);

  // Map pattern to value; anything unrecognised flags an error
  always_comb begin
    o_value    = 4'h0;
    o_is_blank = 1'b0;
    o_is_err   = 1'b0;
    case (i_pattern)
      SEG_0:     o_value = 4'h0;
      SEG_1:     o_value = 4'h1;
      SEG_2:     o_value = 4'h2;
      SEG_3:     o_value = 4'h3;
      SEG_4:     o_value = 4'h4;
      SEG_5:     o_value = 4'h5;
      SEG_6:     o_value = 4'h6;
      SEG_7:     o_value = 4'h7;
      SEG_8:     o_value = 4'h8;
      SEG_9:     o_value = 4'h9;
`ifdef SEG7_HEX_EN
      SEG_A:     o_value = 4'hA;
      SEG_B:     o_value = 4'hB;
      SEG_C:     o_value = 4'hC;
      SEG_D:     o_value = 4'hD;
      SEG_E:     o_value = 4'hE;
      SEG_F:     o_value = 4'hF;
`endif
      SEG_BLANK: o_is_blank = 1'b1;
      default:   o_is_err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reads back a multiplexed active-low 7-segment bus: synchronizes it, waits
// for each digit slot to hold still, decodes it and keeps one value per digit.
// Optional feature macro: SEG7_HEX_EN (hex letter decode, see decoder).
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DIGITS-1:0]     i_an,
  input  logic [6:0]            i_seg,
  output logic [4*DIGITS-1:0]   o_digit,
  output logic [DIGITS-1:0]     o_valid,
  output logic [DIGITS-1:0]     o_err,
  output logic                  o_update,
  output logic                  o_frame
);

  localparam int CW = $clog2(STABLE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);

  logic [DIGITS-1:0] r_an_s1, r_an_s2, r_an_prev;
  logic [6:0]        r_seg_s1, r_seg_s2, r_seg_prev;
  logic [CW-1:0]     r_cnt;
  state_t            r_state, w_state_next;
  logic              w_capture;
  logic [DIGITS-1:0] r_seen;
  logic [DIGITS-1:0] w_an_act;
  logic [DIGITS-1:0] w_seen_sum;
  logic              w_legal;
  logic              w_change;
  logic [3:0]        w_value;
  logic              w_is_blank, w_is_err;
  logic              r_update, r_frame;
  logic [3:0]        r_digit [DIGITS];
  logic              r_valid [DIGITS];
  logic              r_err   [DIGITS];

  // Two-flop synchronizer plus one-cycle history for change detection;
  // everything resets to the idle (all-high) bus
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_an_s1    <= '1;
      r_an_s2    <= '1;
      r_an_prev  <= '1;
      r_seg_s1   <= '1;
      r_seg_s2   <= '1;
      r_seg_prev <= '1;
    end else begin
      r_an_s1    <= i_an;
      r_an_s2    <= r_an_s1;
      r_an_prev  <= r_an_s2;
      r_seg_s1   <= i_seg;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
    end
  end

  // Anode and segment changes are lumped together as a single change event
  assign w_change   = {r_an_s2, r_seg_s2} != {r_an_prev, r_seg_prev};
  assign w_an_act   = ~r_an_s2;
  assign w_legal    = (w_an_act != '0) && ((w_an_act & (w_an_act - 1'b1)) == '0);
  assign w_seen_sum = r_seen | w_an_act;

  seg7_pattern_decode u_decode (
    .i_pattern  (r_seg_s2),
    .o_value    (w_value),
    .o_is_blank (w_is_blank),
    .o_is_err   (w_is_err)
  );

  // Stability counter: restarts on any change or while idle, saturates at max
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_change || (r_state == ST_IDLE)) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // FSM next state and capture strobe; a held value captures only once
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_legal) w_state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (w_change) begin
          w_state_next = w_legal ? ST_SETTLE : ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_capture    = 1'b1;
          w_state_next = ST_HELD;
        end
      end
      ST_HELD: begin
        if (w_change) w_state_next = w_legal ? ST_SETTLE : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Update pulse and frame mask; the frame fires with the capture that
  // completes the mask and the mask restarts empty
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_update <= 1'b0;
      r_frame  <= 1'b0;
      r_seen   <= '0;
    end else begin
      r_update <= w_capture;
      r_frame  <= 1'b0;
      if (w_capture) begin
        if (&w_seen_sum) begin
          r_frame <= 1'b1;
          r_seen  <= '0;
        end else begin
          r_seen  <= w_seen_sum;
        end
      end
    end
  end

  // Per-digit value/valid/error registers, selected by the active anode
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      // Capture into this slot when its anode is the one being held
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_digit[gi] <= 4'h0;
          r_valid[gi] <= 1'b0;
          r_err[gi]   <= 1'b0;
        end else if (w_capture && w_an_act[gi]) begin
          if (!w_is_blank && !w_is_err) begin
            r_digit[gi] <= w_value;
            r_valid[gi] <= 1'b1;
            r_err[gi]   <= 1'b0;
          end else begin
            r_valid[gi] <= 1'b0;
            r_err[gi]   <= w_is_err;
          end
        end
      end

      assign o_digit[4*gi +: 4] = r_digit[gi];
      assign o_valid[gi]        = r_valid[gi];
      assign o_err[gi]          = r_err[gi];
    end
  endgenerate

  assign o_update = r_update;
  assign o_frame  = r_frame;

endmodule
